// File: rtl/fpadd_sched.sv
// Round-robin scheduler sharing one multi-cycle fpadd among NREQ requesters.
// Results come back tagged with the requester ID; a watchdog bounds the wait for done.
//
// state | meaning
// IDLE  | arbitrate from ptr; on a hit capture operands, pulse req_ready
// ISSUE | one-cycle fa_start, clear watchdog
// WAIT  | guard cycle, then wait for fa_done or watchdog terminal count
// RESP  | hold result until rsp_ready
module fpadd_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_sum,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_err,
    output logic                 fa_start,
    output logic [31:0]          fa_a,
    output logic [31:0]          fa_b,
    input  logic [31:0]          fa_sum,
    input  logic                 fa_done
);

    localparam int WDW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] ptr, ptr_nx, gid, gnt_idx, cand_idx;
    logic [31:0]    op_a, op_b, gnt_a, gnt_b;
    logic [WDW-1:0] wd;
    logic           guard, hit, take, done_hit, wd_tc;
    int             cand;

    // Search ptr, ptr+1, ... wrapping at NREQ; first valid requester wins.
    always_comb begin
        hit      = 1'b0;
        gnt_idx  = '0;
        gnt_a    = '0;
        gnt_b    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ)
                cand = cand - NREQ;
            cand_idx = IDW'(cand);
            if (!hit && req_valid[cand_idx]) begin
                hit     = 1'b1;
                gnt_idx = cand_idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) begin
                gnt_a = req_a[32*i +: 32];
                gnt_b = req_b[32*i +: 32];
            end
        end
        ptr_nx = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        fa_start  = 1'b0;
        rsp_valid = 1'b0;
        take      = 1'b0;
        done_hit  = 1'b0;
        wd_tc     = 1'b0;
        case (state)
            IDLE: begin
                // No grant while reset is held, so req_ready stays at its reset value.
                if (hit && !reset) begin
                    req_ready[gnt_idx] = 1'b1;
                    take               = 1'b1;
                    state_nx           = ISSUE;
                end
            end
            ISSUE: begin
                fa_start = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                done_hit = !guard && fa_done;
                wd_tc    = (wd == WDW'(TIMEOUT-1));
                if (done_hit || wd_tc)
                    state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            gid     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            rsp_sum <= '0;
            rsp_err <= 1'b0;
            wd      <= '0;
            guard   <= 1'b0;
        end else begin
            state <= state_nx;
            if (take) begin
                op_a <= gnt_a;
                op_b <= gnt_b;
                gid  <= gnt_idx;
                ptr  <= ptr_nx;
            end
            if (state == ISSUE) begin
                wd    <= '0;
                guard <= 1'b1;
            end
            // The guard cycle ignores a done left high by the previous operation.
            if (state == WAIT) begin
                guard <= 1'b0;
                if (done_hit) begin
                    rsp_sum <= fa_sum;
                    rsp_err <= 1'b0;
                end else if (wd_tc) begin
                    rsp_sum <= '0;
                    rsp_err <= 1'b1;
                end else begin
                    wd <= wd + 1'b1;
                end
            end
        end
    end

    assign fa_a   = op_a;
    assign fa_b   = op_b;
    assign rsp_id = gid;

endmodule

// File: tb/tb_fpadd_sched.sv
// Bench for fpadd_sched: stub adder with stale done, expected responses queued
// by the stimulus and popped by an independent response monitor.
module tb_fpadd_sched;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 8;
    localparam int LAT     = 3;

    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] F4 = 32'h4080_0000;
    localparam logic [31:0] F5 = 32'h40A0_0000;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        err;
    } rsp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [32*NREQ-1:0]   req_a = '0;
    logic [32*NREQ-1:0]   req_b = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [31:0]          rsp_sum;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_err;
    logic                 fa_start;
    logic [31:0]          fa_a, fa_b;
    logic [31:0]          fa_sum = '0;
    logic                 fa_done = 1'b0;

    logic                 hang = 1'b0;
    logic                 hung = 1'b0;
    int                   cnt = 0;
    logic [31:0]          pend = '0;

    int   checks = 0;
    int   failures = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;
    int   lat, starts;

    always #5 clk = ~clk;

    fpadd_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_id(rsp_id), .rsp_err(rsp_err),
        .fa_start(fa_start), .fa_a(fa_a), .fa_b(fa_b),
        .fa_sum(fa_sum), .fa_done(fa_done)
    );

    function automatic logic [31:0] add_tab(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {F1, F1}: return F2;
            {F2, F1}: return F3;
            {F1, F2}: return F3;
            {F3, F1}: return F4;
            {F4, F1}: return F5;
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Stub adder: done stays high one cycle past start, result LAT cycles later.
    always @(posedge clk) begin
        if (fa_start) begin
            cnt  <= hang ? 0 : LAT;
            hung <= hang;
            pend <= add_tab(fa_a, fa_b);
        end else if (cnt > 1) begin
            cnt     <= cnt - 1;
            fa_done <= 1'b0;
        end else if (cnt == 1) begin
            cnt     <= 0;
            fa_done <= 1'b1;
            fa_sum  <= pend;
        end else if (hung) begin
            fa_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: got id=%0d sum=%h err=%0b, required no response",
                         rsp_id, rsp_sum, rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (rsp_id !== mon_e.id || rsp_sum !== mon_e.sum || rsp_err !== mon_e.err) begin
                    failures++;
                    $display("FAIL rsp: got id=%0d sum=%h err=%0b, required id=%0d sum=%h err=%0b",
                             rsp_id, rsp_sum, rsp_err, mon_e.id, mon_e.sum, mon_e.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_ready(input logic [3:0] exp, input string name);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready != 4'b0)
                break;
        end
        chk(name, 32'(req_ready), 32'(exp));
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0 && !rsp_valid)
                break;
            @(negedge clk);
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of run, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_sum",   rsp_sum, 32'd0);
        chk("rst_rsp_id",    32'(rsp_id), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err), 32'd0);
        chk("rst_fa_start",  32'(fa_start), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_fa_a",      fa_a, 32'd0);

        // single op from requester 2
        @(posedge clk); #1;
        exp_q.push_back('{2'd2, F3, 1'b0});
        set_req(2, F1, F2);
        wait_ready(4'b0100, "single_grant");
        @(posedge clk); #1 clr_req(2);
        lat = 0; starts = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (fa_start) starts++;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        chk("single_latency", 32'(lat), 32'(LAT + 3));
        chk("single_starts",  32'(starts), 32'd1);
        drain();

        // contention: all four valid from reset
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < NREQ; i++)
            set_req(i, add_tab(F1, F1) == F2 ? 32'(F1 + 32'(i) * 32'h0) : F1, F1);
        set_req(0, F1, F1);
        set_req(1, F2, F1);
        set_req(2, F3, F1);
        set_req(3, F4, F1);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back('{2'd0, F2, 1'b0});
            exp_q.push_back('{2'd1, F3, 1'b0});
            exp_q.push_back('{2'd2, F4, 1'b0});
            exp_q.push_back('{2'd3, F5, 1'b0});
        end
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b0;
        for (int r = 0; r < 8; r++)
            wait_ready(4'(1 << (r % 4)), "contend_grant");
        @(posedge clk); #1 req_valid = '0;
        drain();

        // fairness: requesters 0 and 3
        @(posedge clk); #1;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back('{2'd0, F2, 1'b0});
            exp_q.push_back('{2'd3, F5, 1'b0});
        end
        set_req(0, F1, F1);
        set_req(3, F4, F1);
        for (int r = 0; r < 4; r++)
            wait_ready((r % 2 == 0) ? 4'b0001 : 4'b1000, "fair_grant");
        @(posedge clk); #1 req_valid = '0;
        drain();

        // backpressure in RESP
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_q.push_back('{2'd1, F3, 1'b0});
        set_req(1, F2, F1);
        wait_ready(4'b0010, "bp_grant");
        @(posedge clk); #1;
        clr_req(1);
        exp_q.push_back('{2'd0, F2, 1'b0});
        set_req(0, F1, F1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_sum", rsp_sum, F3);
            chk("bp_ctl", 32'({rsp_valid, rsp_id, req_ready, fa_start}), 32'({1'b1, 2'd1, 4'b0000, 1'b0}));
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_regrant", 32'(req_ready), 32'b0001);
        @(posedge clk); #1 clr_req(0);
        drain();

        // watchdog: adder never completes
        @(posedge clk); #1;
        hang = 1'b1;
        exp_q.push_back('{2'd2, 32'd0, 1'b1});
        set_req(2, F1, F2);
        wait_ready(4'b0100, "wd_grant");
        @(posedge clk); #1 clr_req(2);
        for (int k = 0; k < 10; k++) begin
            if (fa_start) break;
            @(negedge clk);
        end
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        chk("wd_latency_in_range", 32'(lat >= TIMEOUT && lat <= TIMEOUT + 2), 32'd1);
        @(posedge clk); #1 hang = 1'b0;
        drain();
        @(posedge clk); #1;
        exp_q.push_back('{2'd3, F5, 1'b0});
        set_req(3, F4, F1);
        wait_ready(4'b1000, "wd_next_grant");
        @(posedge clk); #1 clr_req(3);
        drain();

        // reset during WAIT
        @(posedge clk); #1;
        set_req(1, F2, F1);
        wait_ready(4'b0010, "rst_wait_grant");
        @(posedge clk); #1 clr_req(1);
        for (int k = 0; k < 10; k++) begin
            if (fa_start) break;
            @(negedge clk);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_fa_start",  32'(fa_start), 32'd0);
        chk("midrst_rsp_sum",   rsp_sum, 32'd0);
        chk("midrst_rsp_id",    32'(rsp_id), 32'd0);
        chk("midrst_fa_a",      fa_a, 32'd0);
        @(posedge clk); #1;
        exp_q.push_back('{2'd0, F2, 1'b0});
        exp_q.push_back('{2'd3, F4, 1'b0});
        set_req(0, F1, F1);
        set_req(3, F3, F1);
        wait_ready(4'b0001, "midrst_ptr_grant");
        @(posedge clk); #1 clr_req(0);
        wait_ready(4'b1000, "midrst_second_grant");
        @(posedge clk); #1 clr_req(3);
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
